// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Sixteen-source interrupt controller with an 8-byte CPU register window.
// Each raw source level is synchronised, rising edges latch into PEND, and
// PEND & MASK (ACT) drives an active-low interrupt request. Reading the ID
// register acknowledges the lowest-index active source and forces irq_n high
// for HOLDOFF cycles.
//
// Register window (offset from BASE_ADDR):
//   0  PEND[7:0]   read, write-1-to-clear
//   1  PEND[15:8]  read, write-1-to-clear
//   2  MASK[7:0]   read/write
//   3  MASK[15:8]  read/write
//   4  ID          read only: {valid, 3'b0, idx}; starting a read acknowledges
//   5  CTRL        bit0 GEN (global enable), bits 7:1 read 0
//   6,7            reserved: read 0, writes ignored
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   src    in   16 raw asynchronous interrupt source levels
//   addr   in   16-bit CPU address
//   din    in   8-bit CPU write data
//   wr_en  in   write strobe (may be held several cycles; acts once)
//   rd_en  in   read strobe (may be held several cycles)
//   dout   out  read data, combinational from registered state
//   hit    out  addr lies within BASE_ADDR..BASE_ADDR+7
//   irq_n  out  registered active-low interrupt request
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  // Cycles irq_n is forced high after an acknowledge; must be at least 1.
  parameter int          HOLDOFF   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] src,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [7:0]  dout,
  output logic        hit,
  output logic        irq_n
);

  localparam int CW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD
  } state_t;

  // Register offsets inside the window.
  localparam logic [2:0] OFF_PEND_LO = 3'd0;
  localparam logic [2:0] OFF_PEND_HI = 3'd1;
  localparam logic [2:0] OFF_MASK_LO = 3'd2;
  localparam logic [2:0] OFF_MASK_HI = 3'd3;
  localparam logic [2:0] OFF_ID      = 3'd4;
  localparam logic [2:0] OFF_CTRL    = 3'd5;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [15:0]   sync1;
  logic [15:0]   sync2;
  logic [15:0]   prev;
  logic [1:0]    warm;      // counts edges since reset until the sync chain holds real samples
  logic [15:0]   pend;
  logic [15:0]   mask;
  logic          gen;
  logic          wr_en_q;
  logic          rd_en_q;
  logic [7:0]    id_hold;
  logic [CW-1:0] cnt;
  state_t        state;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  // 17-bit difference: an address below BASE_ADDR wraps to a large value,
  // so one unsigned compare covers both ends of the window.
  logic [16:0] rel;
  logic [2:0]  offset;

  assign rel    = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit    = (rel < 17'd8);
  assign offset = rel[2:0];

  // Accesses act only on the first cycle of a strobe that hits the window.
  logic wr_start;
  logic rd_start;
  logic id_rd_start;

  assign wr_start    = wr_en & ~wr_en_q & hit;
  assign rd_start    = rd_en & ~rd_en_q & hit;
  assign id_rd_start = rd_start & (offset == OFF_ID);

  // -------------------------------------------------------------------------
  // Edge detection
  // -------------------------------------------------------------------------
  // The synchronisers come out of reset holding zero rather than the real
  // source level, so a source held high across reset would look like a new
  // rising edge. Edges are ignored until sync2 and prev both carry samples
  // taken after reset was released.
  logic        edge_en;
  logic [15:0] rise;

  assign edge_en = (warm == 2'd3);
  assign rise    = sync2 & ~prev & {16{edge_en}};

  // -------------------------------------------------------------------------
  // Active sources and ID
  // -------------------------------------------------------------------------
  logic [15:0] act;
  logic        any_act;
  logic [3:0]  idx;
  logic [7:0]  id;

  assign act     = pend & mask;
  assign any_act = |act;

  // Lowest-index set bit wins: scanning downward lets the last match stand.
  // NOTE: every variable written in a combinational block gets a default
  // first, otherwise paths that skip the assignment infer a latch.
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) idx = 4'(i);
    end
  end

  assign id = {any_act, 3'b000, idx};

  // -------------------------------------------------------------------------
  // PEND clear sources: W1C writes and the ID auto-acknowledge
  // -------------------------------------------------------------------------
  logic [15:0] pend_clr;

  always_comb begin
    pend_clr = '0;
    if (wr_start && offset == OFF_PEND_LO) pend_clr[7:0]  = din;
    if (wr_start && offset == OFF_PEND_HI) pend_clr[15:8] = din;
    if (id_rd_start && any_act)            pend_clr[idx]  = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the clock edge, independent of the
  // order of statements or blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      warm    <= '0;
      pend    <= '0;
      mask    <= '0;
      gen     <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      id_hold <= '0;
    end else begin
      sync1   <= src;
      sync2   <= sync1;
      prev    <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      wr_en_q <= wr_en;
      rd_en_q <= rd_en;

      // A new edge outranks a clear landing on the same bit.
      pend <= (pend & ~pend_clr) | rise;

      if (wr_start) begin
        case (offset)
          OFF_MASK_LO: mask[7:0]  <= din;
          OFF_MASK_HI: mask[15:8] <= din;
          OFF_CTRL:    gen        <= din[0];
          default:     ;
        endcase
      end

      if (rd_start) id_hold <= id;
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt FSM; irq_n is written alongside the next state so it is a
  // registered decode of that state.
  // -------------------------------------------------------------------------
  // When the HOLD count expires the IDLE decision is taken on that same edge,
  // so irq_n is forced high for exactly HOLDOFF cycles and can fall again
  // immediately if sources are still active.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      irq_n <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gen && any_act) begin
            state <= ASSERT;
            irq_n <= 1'b0;
          end
        end

        ASSERT: begin
          if (id_rd_start) begin
            state <= HOLD;
            irq_n <= 1'b1;
            cnt   <= CW'(HOLDOFF - 1);
          end else if (!(gen && any_act)) begin
            state <= IDLE;
            irq_n <= 1'b1;
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            if (gen && any_act) begin
              state <= ASSERT;
              irq_n <= 1'b0;
            end else begin
              state <= IDLE;
              irq_n <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          irq_n <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read data
  // -------------------------------------------------------------------------
  // During a held ID read the value latched at the start is returned so it
  // cannot change under the CPU; on the first cycle the live ID equals what
  // is being latched.
  always_comb begin
    dout = '0;
    if (hit) begin
      case (offset)
        OFF_PEND_LO: dout = pend[7:0];
        OFF_PEND_HI: dout = pend[15:8];
        OFF_MASK_LO: dout = mask[7:0];
        OFF_MASK_HI: dout = mask[15:8];
        OFF_ID:      dout = (rd_en && rd_en_q) ? id_hold : id;
        OFF_CTRL:    dout = {7'b0, gen};
        default:     dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//
// Drives directed scenarios followed by random CPU traffic and source
// toggling. A reference model, expressed as sample histories and cycle
// numbers rather than registers and states, predicts every cycle's irq_n,
// hit and (during reads) dout; predictions are queued and a separate
// monitor compares them against the DUT on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_irq_controller;

  localparam logic [15:0] BASE    = 16'hFE00;
  localparam int          HOLDOFF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  dout;
  logic        hit;
  logic        irq_n;

  always #5 clk = ~clk;

  irq_controller #(
    .BASE_ADDR (BASE),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .addr  (addr),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .hit   (hit),
    .irq_n (irq_n)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    bit         chk_dout;
    logic [7:0] dout;
    logic       hit;
    logic       irq_n;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  bit [15:0] m_pend;
  bit [15:0] m_mask;
  bit        m_gen;
  bit        m_wr_prev;     // wr_en level seen at the previous edge
  bit        m_rd_prev;     // rd_en level seen at the previous edge
  bit [7:0]  m_id_hold;
  bit        m_irq_low;
  int        m_hold_end;    // irq_n is forced high at edges before this number
  int        m_cyc;
  bit [15:0] m_log[$];      // src samples taken since reset, newest last

  logic [15:0] cur_src;

  function automatic bit m_hit(logic [15:0] a);
    int ai;
    ai = int'(a);
    return (ai >= int'(BASE)) && (ai <= int'(BASE) + 7);
  endfunction

  function automatic int m_off(logic [15:0] a);
    return int'(a) - int'(BASE);
  endfunction

  function automatic bit [7:0] m_id();
    bit [15:0] act;
    act = m_pend & m_mask;
    for (int i = 0; i < 16; i++) begin
      if (act[i]) return {1'b1, 3'b000, 4'(i)};
    end
    return 8'h00;
  endfunction

  function automatic bit [7:0] m_dout(logic [15:0] a, bit r);
    if (!m_hit(a)) return 8'h00;
    case (m_off(a))
      0: return m_pend[7:0];
      1: return m_pend[15:8];
      2: return m_mask[7:0];
      3: return m_mask[15:8];
      4: return (r && m_rd_prev) ? m_id_hold : m_id();
      5: return {7'b0, m_gen};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_clear();
    m_pend     = '0;
    m_mask     = '0;
    m_gen      = 1'b0;
    m_wr_prev  = 1'b0;
    m_rd_prev  = 1'b0;
    m_id_hold  = '0;
    m_irq_low  = 1'b0;
    m_hold_end = 0;
    m_log.delete();
  endtask

  // Advance the model across one rising edge with the inputs present there.
  task automatic model_edge(bit rst, logic [15:0] s, logic [15:0] a,
                            logic [7:0] d, bit w, bit r);
    bit [15:0] rise;
    bit [15:0] clr;
    bit [7:0]  old_id;
    bit        active;
    bit        h;
    bit        ws;
    bit        rs;
    int        off;

    m_cyc++;
    if (rst) begin
      model_clear();
      return;
    end

    // A rising edge is a 0->1 step between two consecutive post-reset
    // samples; it lands in PEND two edges after the later sample.
    rise = '0;
    m_log.push_back(s);
    if (m_log.size() > 4) void'(m_log.pop_front());
    if (m_log.size() == 4) rise = m_log[1] & ~m_log[0];

    h      = m_hit(a);
    off    = m_off(a);
    ws     = w && !m_wr_prev && h;
    rs     = r && !m_rd_prev && h;
    old_id = m_id();
    active = (|(m_pend & m_mask)) && m_gen;

    clr = '0;
    if (ws && off == 0) clr[7:0]  = d;
    if (ws && off == 1) clr[15:8] = d;
    if (rs && off == 4 && old_id[7]) clr[old_id[3:0]] = 1'b1;

    if (m_cyc < m_hold_end) begin
      m_irq_low = 1'b0;
    end else if (m_irq_low && rs && off == 4) begin
      m_irq_low  = 1'b0;
      m_hold_end = m_cyc + HOLDOFF;
    end else begin
      m_irq_low = active;
    end

    if (rs) m_id_hold = old_id;
    m_pend = (m_pend & ~clr) | rise;
    if (ws && off == 2) m_mask[7:0]  = d;
    if (ws && off == 3) m_mask[15:8] = d;
    if (ws && off == 5) m_gen        = d[0];
    m_wr_prev = w;
    m_rd_prev = r;
  endtask

  // -------------------------------------------------------------------------
  // Driver helpers: each step applies inputs just after a rising edge,
  // queues the prediction for the coming falling edge, then advances the
  // model across the next rising edge.
  // -------------------------------------------------------------------------
  task automatic step(bit rst, logic [15:0] a, logic [7:0] d, bit w, bit r);
    exp_t e;
    reset = rst;
    src   = cur_src;
    addr  = a;
    din   = d;
    wr_en = w;
    rd_en = r;
    e.chk_dout = r;
    e.dout     = m_dout(a, r);
    e.hit      = m_hit(a);
    e.irq_n    = !m_irq_low;
    e.cyc      = m_cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    model_edge(rst, cur_src, a, d, w, r);
  endtask

  function automatic logic [15:0] ra(int off);
    return BASE + 16'(off);
  endfunction

  task automatic idle(int n);
    repeat (n) step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr_reg(int off, logic [7:0] d);
    step(1'b0, ra(off), d, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic rd_reg(int off, int n);
    repeat (n) step(1'b0, ra(off), 8'h00, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic do_reset(int n);
    repeat (n) step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  task automatic check(string name, int cyc, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at model cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("irq_n", e.cyc, {7'b0, irq_n}, {7'b0, e.irq_n});
        check("hit",   e.cyc, {7'b0, hit},   {7'b0, e.hit});
        if (e.chk_dout) check("dout", e.cyc, dout, e.dout);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int len;
    int op;
    logic [15:0] a;
    logic [7:0]  d;
    bit          w;
    bit          r;
    bit [2:0]    b37 [3];

    cur_src = '0;
    reset   = 1'b1;
    src     = '0;
    addr    = '0;
    din     = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    m_cyc   = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Reset state, then src[3] through MASK_LO=0x08 and GEN.
    do_reset(2);
    rd_reg(4, 1);
    rd_reg(5, 1);
    wr_reg(2, 8'h08);
    wr_reg(5, 8'h01);
    cur_src[3] = 1'b1;
    idle(5);
    rd_reg(0, 1);
    rd_reg(4, 1);
    idle(6);

    // Bits 3 and 9 pending, full mask, six-cycle ID read then holdoff.
    wr_reg(2, 8'hFF);
    wr_reg(3, 8'hFF);
    cur_src[3] = 1'b0;
    idle(2);
    cur_src[3] = 1'b1;
    cur_src[9] = 1'b1;
    idle(5);
    rd_reg(4, 6);
    idle(8);
    rd_reg(0, 1);
    rd_reg(1, 1);
    rd_reg(4, 1);
    idle(6);

    // New edge on src[5] collides with a W1C of bit 5.
    cur_src[5] = 1'b1;
    idle(4);
    cur_src[5] = 1'b0;
    idle(3);
    cur_src[5] = 1'b1;
    idle(2);
    step(1'b0, ra(0), 8'h20, 1'b1, 1'b0);
    idle(1);
    rd_reg(0, 1);

    // Masked src[2] latches, then unmasking raises the interrupt.
    wr_reg(2, 8'h00);
    wr_reg(3, 8'h00);
    wr_reg(0, 8'hFF);
    wr_reg(1, 8'hFF);
    idle(6);
    cur_src[2] = 1'b1;
    idle(4);
    rd_reg(0, 1);
    wr_reg(2, 8'h04);
    idle(2);
    rd_reg(4, 1);
    idle(5);

    // Five-cycle held W1C while edges arrive on cycles 2-4.
    wr_reg(2, 8'hFF);
    wr_reg(0, 8'hFF);
    wr_reg(1, 8'hFF);
    b37[0] = 3'd0;
    b37[1] = 3'd1;
    b37[2] = 3'd6;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) cur_src[b37[c]] = 1'b1;
      step(1'b0, ra(0), 8'hFF, 1'b1, 1'b0);
    end
    idle(1);
    rd_reg(0, 1);

    // Reset during HOLD with src[0] held high.
    idle(2);
    rd_reg(4, 1);
    idle(1);
    do_reset(2);
    idle(6);
    wr_reg(2, 8'hFF);
    wr_reg(3, 8'hFF);
    wr_reg(5, 8'h01);
    idle(6);
    rd_reg(0, 1);
    rd_reg(1, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur_src[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 2));
        continue;
      end
      a   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : ra($urandom_range(0, 7));
      d   = 8'($urandom);
      op  = $urandom_range(0, 2);
      len = $urandom_range(1, 3);
      w   = (op == 1);
      r   = (op == 2);
      if (w && a == ra(5) && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 3) == 0) cur_src[$urandom_range(0, 15)] ^= 1'b1;
        step(1'b0, a, d, w, r);
      end
      idle($urandom_range(0, 2));
    end

    idle(2);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
